ad9361_ensm_seq: RTL

//  Pin-control ENSM sequencer for the AD9361. Drives the enable/txnrx pins of the PL

---
 rtl/ad9361_ensm_pkg.sv | 34 +++
 rtl/ensm_dwell_cnt.sv | 28 ++
 rtl/ad9361_ensm_seq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ad9361_ensm_pkg.sv
// Shared encodings for the AD9361 pin-control ENSM sequencer.
// The mode and state values match the req_mode and state port encodings.
package ad9361_ensm_pkg;

  localparam int MODE_W  = 2;
  localparam int STATE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_ALERT = 2'd0,
    MODE_RX    = 2'd1,
    MODE_TX    = 2'd2,
    MODE_FDD   = 2'd3
  } ensm_mode_e;

  typedef enum logic [STATE_W-1:0] {
    ST_ALERT  = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HOLD   = 2'd3
  } ensm_state_e;

  function automatic logic mode_txnrx(input ensm_mode_e m);
    return (m == MODE_TX) || (m == MODE_FDD);
  endfunction

  function automatic logic mode_has_rx(input ensm_mode_e m);
    return (m == MODE_RX) || (m == MODE_FDD);
  endfunction

  function automatic logic mode_has_tx(input ensm_mode_e m);
    return (m == MODE_TX) || (m == MODE_FDD);
  endfunction

endpackage

// File: rtl/ensm_dwell_cnt.sv
// Loadable down-counter that saturates at zero; done flags the terminal count.
// A load value of N-1 keeps the owning state resident for exactly N cycles.
module ensm_dwell_cnt #(
  parameter int              CNT_W   = 16,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/ad9361_ensm_seq.sv
// Pin-control ENSM sequencer: turns mode requests into ENABLE/TXNRX pin sequences
// with txnrx setup/hold around enable and a minimum ALERT dwell between modes.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  ALERT  | enable low; dwell runs; accepts requests or manual override
//  SETUP  | txnrx driven for the new mode, waiting before enable rises
//  ACTIVE | enable high; rx/tx_active reflect the current mode
//  HOLD   | enable low, txnrx held before returning to ALERT
module ad9361_ensm_seq
  import ad9361_ensm_pkg::*;
#(
  parameter int SETUP_CYCLES = 4,
  parameter int HOLD_CYCLES  = 4,
  parameter int ALERT_CYCLES = 8,
  parameter int CNT_W        = 16
) (
  input  logic                axi_aclk,
  input  logic                axi_areset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [MODE_W-1:0]   req_mode,
  input  logic                man_en,
  input  logic                up_enable,
  input  logic                up_txnrx,
  output logic                enable,
  output logic                txnrx,
  output logic                rx_active,
  output logic                tx_active,
  output logic                mode_done,
  output logic [STATE_W-1:0]  state
);

  localparam int CNT_MAX = (CNT_W >= 1 && CNT_W <= 30) ? ((1 << CNT_W) - 1) : 0;

  if (CNT_W < 1 || CNT_W > 30 ||
      SETUP_CYCLES < 1 || SETUP_CYCLES > CNT_MAX ||
      HOLD_CYCLES  < 1 || HOLD_CYCLES  > CNT_MAX ||
      ALERT_CYCLES < 1 || ALERT_CYCLES > CNT_MAX) begin : g_param_err
    $error("ad9361_ensm_seq: dwell parameter out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALERT_LD = CNT_W'(ALERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALERT_RST = CNT_W'(ALERT_CYCLES);

  ensm_state_e state_q, state_nxt;
  ensm_mode_e  cur_q, cur_nxt;
  ensm_mode_e  pend_mode_q, pend_mode_nxt;
  ensm_mode_e  req_m;
  logic        pend_vld_q, pend_vld_nxt;
  logic        alert_pend_q, alert_pend_nxt;
  logic        enable_q, enable_nxt;
  logic        txnrx_q, txnrx_nxt;
  logic        mode_done_q, mode_done_nxt;
  logic        man_q;
  logic        accept;
  logic        cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic        dwell_done;

  ensm_dwell_cnt #(
    .CNT_W   (CNT_W),
    .RST_VAL (ALERT_RST)
  ) u_dwell (
    .clk      (axi_aclk),
    .rst      (axi_areset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (dwell_done)
  );

  assign req_m     = ensm_mode_e'(req_mode);
  // A queued mode change owns the next ALERT exit, so nothing new is taken meanwhile.
  assign req_ready = !man_en &&
                     (((state_q == ST_ALERT) && dwell_done && !pend_vld_q) ||
                      (state_q == ST_ACTIVE));
  assign accept    = req_valid && req_ready;

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q      <= ST_ALERT;
      cur_q        <= MODE_ALERT;
      pend_mode_q  <= MODE_ALERT;
      pend_vld_q   <= 1'b0;
      alert_pend_q <= 1'b0;
      enable_q     <= 1'b0;
      txnrx_q      <= 1'b0;
      mode_done_q  <= 1'b0;
      man_q        <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      cur_q        <= cur_nxt;
      pend_mode_q  <= pend_mode_nxt;
      pend_vld_q   <= pend_vld_nxt;
      alert_pend_q <= alert_pend_nxt;
      enable_q     <= enable_nxt;
      txnrx_q      <= txnrx_nxt;
      mode_done_q  <= mode_done_nxt;
      man_q        <= man_en;
    end
  end

  always_comb begin
    state_nxt      = state_q;
    cur_nxt        = cur_q;
    pend_mode_nxt  = pend_mode_q;
    pend_vld_nxt   = pend_vld_q;
    alert_pend_nxt = alert_pend_q;
    enable_nxt     = enable_q;
    txnrx_nxt      = txnrx_q;
    mode_done_nxt  = 1'b0;
    cnt_load       = 1'b0;
    cnt_val        = '0;

    unique case (state_q)
      ST_ALERT: begin
        enable_nxt = 1'b0;
        if (pend_vld_q) begin
          if (dwell_done) begin
            state_nxt    = ST_SETUP;
            cur_nxt      = pend_mode_q;
            txnrx_nxt    = mode_txnrx(pend_mode_q);
            pend_vld_nxt = 1'b0;
            cnt_load     = 1'b1;
            cnt_val      = SETUP_LD;
          end
        end else if (man_en) begin
          enable_nxt = up_enable;
          txnrx_nxt  = up_txnrx;
        end else begin
          if (man_q) begin
            cnt_load = 1'b1;
            cnt_val  = ALERT_LD;
          end
          if (accept) begin
            if (req_m == MODE_ALERT) begin
              mode_done_nxt = 1'b1;
            end else begin
              state_nxt = ST_SETUP;
              cur_nxt   = req_m;
              txnrx_nxt = mode_txnrx(req_m);
              cnt_load  = 1'b1;
              cnt_val   = SETUP_LD;
            end
          end
        end
      end
      ST_SETUP: begin
        if (dwell_done) begin
          state_nxt     = ST_ACTIVE;
          enable_nxt    = 1'b1;
          mode_done_nxt = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (accept) begin
          if (req_m == cur_q) begin
            mode_done_nxt = 1'b1;
          end else begin
            state_nxt  = ST_HOLD;
            enable_nxt = 1'b0;
            cnt_load   = 1'b1;
            cnt_val    = HOLD_LD;
            if (req_m == MODE_ALERT) begin
              alert_pend_nxt = 1'b1;
            end else begin
              pend_vld_nxt  = 1'b1;
              pend_mode_nxt = req_m;
            end
          end
        end
      end
      ST_HOLD: begin
        if (dwell_done) begin
          state_nxt = ST_ALERT;
          cur_nxt   = MODE_ALERT;
          cnt_load  = 1'b1;
          cnt_val   = ALERT_LD;
          if (alert_pend_q) begin
            mode_done_nxt  = 1'b1;
            alert_pend_nxt = 1'b0;
          end
        end
      end
      default: state_nxt = ST_ALERT;
    endcase
  end

  assign enable    = enable_q;
  assign txnrx     = txnrx_q;
  assign mode_done = mode_done_q;
  assign state     = state_q;
  assign rx_active = (state_q == ST_ACTIVE) && mode_has_rx(cur_q);
  assign tx_active = (state_q == ST_ACTIVE) && mode_has_tx(cur_q);

endmodule
